// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg (package)
//  Description : Shared types and constants for mem_port_arbiter. It holds
//                the FSM state encoding, the owner tag of the in-flight
//                transaction, and a helper that sizes the streak counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GNT = 2'd1,
        WAIT_RSP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_DATA  = 1'b0,
        OWN_FETCH = 1'b1
    } arb_owner_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int BE_WIDTH       = DEF_DATA_WIDTH / 8;

    // The counter must be able to hold the value max_streak itself.
    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage : arb_pkg
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_if
//  Description : Bundles the fetch port, the data port and the memory port
//                of the arbiter.
//                  slave  : view from the arbiter
//                  master : view from the environment (pipeline + memory)
//  Ports       : Fetch*  - instruction read requester
//                Data*   - load/store requester
//                Stall*  - per-requester stall outputs
//                Mem*    - single-port memory handshake
//  Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int BEW = DATA_WIDTH / 8;

    logic                  FetchReq;
    logic [ADDR_WIDTH-1:0] FetchAddr;
    logic [DATA_WIDTH-1:0] FetchRdata;
    logic                  FetchValid;

    logic                  DataReq;
    logic                  DataWe;
    logic [ADDR_WIDTH-1:0] DataAddr;
    logic [DATA_WIDTH-1:0] DataWdata;
    logic [BEW-1:0]        DataBe;
    logic [DATA_WIDTH-1:0] DataRdata;
    logic                  DataValid;

    logic                  StallFetch;
    logic                  StallData;

    logic                  MemReq;
    logic                  MemWe;
    logic [ADDR_WIDTH-1:0] MemAddr;
    logic [DATA_WIDTH-1:0] MemWdata;
    logic [BEW-1:0]        MemBe;
    logic                  MemGnt;
    logic                  MemRvalid;
    logic [DATA_WIDTH-1:0] MemRdata;

    modport slave (
        input  FetchReq, FetchAddr,
        input  DataReq, DataWe, DataAddr, DataWdata, DataBe,
        input  MemGnt, MemRvalid, MemRdata,
        output FetchRdata, FetchValid,
        output DataRdata, DataValid,
        output StallFetch, StallData,
        output MemReq, MemWe, MemAddr, MemWdata, MemBe
    );

    modport master (
        output FetchReq, FetchAddr,
        output DataReq, DataWe, DataAddr, DataWdata, DataBe,
        output MemGnt, MemRvalid, MemRdata,
        input  FetchRdata, FetchValid,
        input  DataRdata, DataValid,
        input  StallFetch, StallData,
        input  MemReq, MemWe, MemAddr, MemWdata, MemBe
    );

endinterface : mem_port_arbiter_if
`default_nettype wire

// File: rtl/mem_port_arbiter_streak_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : arb_streak_ctrl
//  Description : Fixed data-first priority with a starvation guard. It
//                counts consecutive data grants made while fetch waits. Once
//                the count reaches MAX_DATA_STREAK, fetch wins the next
//                arbitration.
//  Ports       : clk, rst   - clock, asynchronous active-high reset
//                fetch_req  - fetch requester is waiting
//                data_req   - data requester is waiting
//                grant_en   - an arbitration is committed this cycle
//                winner     - combinational winner of the current arbitration
//  Revision    : 1.0 - initial release
// ============================================================================
module arb_streak_ctrl
    import arb_pkg::*;
#(
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fetch_req,
    input  logic       data_req,
    input  logic       grant_en,
    output arb_owner_t winner
);

    localparam int              CW         = streak_width(MAX_DATA_STREAK);
    localparam logic [CW-1:0]   STREAK_MAX = CW'(MAX_DATA_STREAK);

    logic [CW-1:0] streak_q;
    logic [CW-1:0] streak_d;
    logic          limit_hit;

    assign limit_hit = (streak_q >= STREAK_MAX);

    // Data wins whenever it asks. The exception is a waiting fetch that has
    // already been passed over MAX_DATA_STREAK times in a row.
    always_comb begin
        winner = OWN_DATA;
        if (fetch_req && (!data_req || limit_hit)) begin
            winner = OWN_FETCH;
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (grant_en) begin
            if (winner == OWN_FETCH) begin
                streak_d = '0;
            end else if (fetch_req) begin
                streak_d = limit_hit ? STREAK_MAX : (streak_q + CW'(1));
            end else begin
                // No one was starved by this grant, so the streak restarts.
                streak_d = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule : arb_streak_ctrl
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-port memory between the fetch stage and
//                the memory stage. It runs one transaction at a time through
//                IDLE -> WAIT_GNT -> WAIT_RSP. The winner's attributes are
//                latched into the Mem* registers at arbitration.
//  Ports       : clk  - clock, rising edge
//                rst  - asynchronous active-high reset
//                bus  - mem_port_arbiter_if.slave (fetch, data, stall and
//                       memory ports)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    localparam int BEW = DATA_WIDTH / 8;

    arb_state_t            state_q,     state_d;
    arb_owner_t            owner_q,     owner_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [BEW-1:0]        mem_be_q,    mem_be_d;

    logic       any_req;
    logic       arb_en;
    logic       rsp_hit;
    arb_owner_t winner;

    assign any_req = bus.FetchReq | bus.DataReq;
    assign arb_en  = (state_q == IDLE) && any_req;

    // A response counts only while one is outstanding. Stray MemRvalid
    // pulses in other states are dropped.
    assign rsp_hit = (state_q == WAIT_RSP) && bus.MemRvalid;

    arb_streak_ctrl #(
        .MAX_DATA_STREAK (MAX_DATA_STREAK)
    ) u_streak_ctrl (
        .clk       (clk),
        .rst       (rst),
        .fetch_req (bus.FetchReq),
        .data_req  (bus.DataReq),
        .grant_en  (arb_en),
        .winner    (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    owner_d   = winner;
                    mem_req_d = 1'b1;
                    state_d   = WAIT_GNT;
                    if (winner == OWN_FETCH) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = bus.FetchAddr;
                        mem_wdata_d = '0;
                        mem_be_d    = '0;
                    end else begin
                        mem_we_d    = bus.DataWe;
                        mem_addr_d  = bus.DataAddr;
                        mem_wdata_d = bus.DataWdata;
                        mem_be_d    = bus.DataBe;
                    end
                end
            end
            WAIT_GNT: begin
                if (bus.MemGnt) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT_RSP;
                end
            end
            WAIT_RSP: begin
                if (bus.MemRvalid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_DATA;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    assign bus.MemReq   = mem_req_q;
    assign bus.MemWe    = mem_we_q;
    assign bus.MemAddr  = mem_addr_q;
    assign bus.MemWdata = mem_wdata_q;
    assign bus.MemBe    = mem_be_q;

    // Completion is reported in the same cycle as MemRvalid, so read data
    // passes straight through to both requesters.
    assign bus.FetchValid = rsp_hit && (owner_q == OWN_FETCH);
    assign bus.DataValid  = rsp_hit && (owner_q == OWN_DATA);
    assign bus.FetchRdata = bus.MemRdata;
    assign bus.DataRdata  = bus.MemRdata;

    assign bus.StallFetch = bus.FetchReq & ~bus.FetchValid;
    assign bus.StallData  = bus.DataReq  & ~bus.DataValid;

endmodule : mem_port_arbiter
`default_nettype wire
